// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: evaluates RISC-V branch conditions from SUB flags,
// issues a handshaked fetch redirect, flushes younger stages and counts branches.
module branch_resolve_unit #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic [2:0]       ex_funct3,
    input  logic [31:0]      ex_target,
    input  logic             n_flag,
    input  logic             z_flag,
    input  logic             c_flag,
    input  logic             v_flag,
    input  logic             redirect_ready,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             stall_ex,
    output logic             misalign_fault,
    output logic             illegal_branch,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        FLUSH
    } state_t;

    localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [31:0] pc_next;
    logic        misalign_next, illegal_next;
    logic        br_inc, tk_inc;
    logic        cond, legal, aligned;

    // Flags come from rs1 - rs2; c is the unsigned borrow.
    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        unique case (ex_funct3)
            3'b000:  cond = z_flag;
            3'b001:  cond = !z_flag;
            3'b100:  cond = n_flag ^ v_flag;
            3'b101:  cond = !(n_flag ^ v_flag);
            3'b110:  cond = c_flag;
            3'b111:  cond = !c_flag;
            default: legal = 1'b0;
        endcase
    end

    assign aligned = (ex_target[1:0] == 2'b00);

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        pc_next       = redirect_pc;
        misalign_next = 1'b0;
        illegal_next  = 1'b0;
        br_inc        = 1'b0;
        tk_inc        = 1'b0;
        unique case (state)
            IDLE: begin
                if (ex_valid && ex_is_jump) begin
                    if (aligned) begin
                        pc_next    = ex_target;
                        state_next = REDIRECT;
                    end else begin
                        misalign_next = 1'b1;
                    end
                end else if (ex_valid && ex_is_branch) begin
                    br_inc       = 1'b1;
                    illegal_next = !legal;
                    if (legal && cond) begin
                        tk_inc = 1'b1;
                        if (aligned) begin
                            pc_next    = ex_target;
                            state_next = REDIRECT;
                        end else begin
                            misalign_next = 1'b1;
                        end
                    end
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = FLUSH;
                        cnt_next   = FLUSH_LOAD;
                    end
                end
            end
            FLUSH: begin
                if (cnt == 4'd0) state_next = IDLE;
                else             cnt_next   = cnt - 4'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered copies of what the next state demands.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            flush_if_id    <= 1'b0;
            flush_id_ex    <= 1'b0;
            stall_ex       <= 1'b0;
            misalign_fault <= 1'b0;
            illegal_branch <= 1'b0;
            branch_cnt     <= '0;
            taken_cnt      <= '0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            redirect_valid <= (state_next == REDIRECT);
            redirect_pc    <= pc_next;
            flush_if_id    <= (state_next != IDLE);
            flush_id_ex    <= (state_next != IDLE);
            stall_ex       <= (state_next != IDLE);
            misalign_fault <= misalign_next;
            illegal_branch <= illegal_next;
            if (br_inc && (branch_cnt != '1)) branch_cnt <= branch_cnt + CNT_ONE;
            if (tk_inc && (taken_cnt != '1))  taken_cnt  <= taken_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; a second instance with CNT_W=4 checks saturation.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_is_branch, ex_is_jump;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_target;
    logic        n_flag, z_flag, c_flag, v_flag;
    logic        redirect_ready;

    logic        redirect_valid, flush_if_id, flush_id_ex, stall_ex;
    logic        misalign_fault, illegal_branch;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt, taken_cnt;

    logic        s_redirect_valid, s_flush_if_id, s_flush_id_ex, s_stall_ex;
    logic        s_misalign_fault, s_illegal_branch;
    logic [31:0] s_redirect_pc;
    logic [3:0]  s_branch_cnt, s_taken_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jump(ex_is_jump), .ex_funct3(ex_funct3), .ex_target(ex_target),
        .n_flag(n_flag), .z_flag(z_flag), .c_flag(c_flag), .v_flag(v_flag),
        .redirect_ready(redirect_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .stall_ex(stall_ex), .misalign_fault(misalign_fault), .illegal_branch(illegal_branch),
        .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    branch_resolve_unit #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jump(ex_is_jump), .ex_funct3(ex_funct3), .ex_target(ex_target),
        .n_flag(n_flag), .z_flag(z_flag), .c_flag(c_flag), .v_flag(v_flag),
        .redirect_ready(redirect_ready), .redirect_valid(s_redirect_valid),
        .redirect_pc(s_redirect_pc), .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex),
        .stall_ex(s_stall_ex), .misalign_fault(s_misalign_fault), .illegal_branch(s_illegal_branch),
        .branch_cnt(s_branch_cnt), .taken_cnt(s_taken_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic br, input logic jmp, input logic [2:0] f3,
                         input logic [31:0] tgt, input logic [3:0] nzcv);
        ex_valid     = 1'b1;
        ex_is_branch = br;
        ex_is_jump   = jmp;
        ex_funct3    = f3;
        ex_target    = tgt;
        {n_flag, z_flag, c_flag, v_flag} = nzcv;
    endtask

    initial begin
        int flush_len;
        rst = 1'b1; ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0;
        ex_funct3 = 3'b000; ex_target = 32'd0;
        {n_flag, z_flag, c_flag, v_flag} = 4'b0000;
        redirect_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        check("reset_valid", redirect_valid, 0);
        check("reset_pc", redirect_pc, 0);
        check("reset_flush", {flush_if_id, flush_id_ex, stall_ex}, 0);
        check("reset_pulses", {misalign_fault, illegal_branch}, 0);
        check("reset_cnts", {branch_cnt, taken_cnt}, 0);

        // BEQ taken; the branch is left asserted through REDIRECT/FLUSH and must be ignored.
        redirect_ready = 1'b1;
        drive(1'b1, 1'b0, 3'b000, 32'h0000_0100, 4'b0100);
        tick();
        check("beq_valid", redirect_valid, 1);
        check("beq_pc", redirect_pc, 32'h100);
        check("beq_flush", {flush_if_id, flush_id_ex, stall_ex}, 3'b111);
        flush_len = 0;
        for (int i = 0; i < 10 && flush_if_id; i++) begin
            flush_len++;
            tick();
        end
        ex_valid = 1'b0;
        check("beq_flush_len", flush_len, 3);
        check("beq_idle", {redirect_valid, flush_id_ex, stall_ex}, 0);
        check("beq_pc_hold", redirect_pc, 32'h100);
        check("beq_cnts", {branch_cnt, taken_cnt}, {32'd1, 32'd1});

        // BLT with n=1,v=1: not taken.
        drive(1'b1, 1'b0, 3'b100, 32'h0000_0200, 4'b1001);
        tick();
        check("blt_no_redirect", redirect_valid, 0);
        check("blt_cnts", {branch_cnt, taken_cnt}, {32'd2, 32'd1});

        // BLTU with c=1: taken.
        drive(1'b1, 1'b0, 3'b110, 32'h0000_0200, 4'b0010);
        tick();
        ex_valid = 1'b0;
        check("bltu_valid", redirect_valid, 1);
        check("bltu_pc", redirect_pc, 32'h200);
        check("bltu_cnts", {branch_cnt, taken_cnt}, {32'd3, 32'd2});
        tick(); tick(); tick();
        check("bltu_idle", flush_if_id, 0);

        // JAL with fetch stalled for 5 cycles.
        redirect_ready = 1'b0;
        drive(1'b0, 1'b1, 3'b000, 32'h0000_2000, 4'b0000);
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("jal_wait_valid", {redirect_valid, stall_ex}, 2'b11);
            check("jal_wait_pc", redirect_pc, 32'h2000);
            if (i < 4) tick();
        end
        redirect_ready = 1'b1;
        tick();
        check("jal_accept_drop", redirect_valid, 0);
        check("jal_flush1", {flush_if_id, flush_id_ex, stall_ex}, 3'b111);
        tick();
        check("jal_flush2", flush_if_id, 1);
        tick();
        check("jal_idle", {flush_if_id, stall_ex}, 0);
        check("jal_cnts", {branch_cnt, taken_cnt}, {32'd3, 32'd2});

        // BNE taken to a misaligned target.
        drive(1'b1, 1'b0, 3'b001, 32'h0000_0102, 4'b0000);
        tick();
        ex_valid = 1'b0;
        check("mis_pulse", misalign_fault, 1);
        check("mis_no_redirect", {redirect_valid, stall_ex}, 0);
        check("mis_pc_hold", redirect_pc, 32'h2000);
        check("mis_cnts", {branch_cnt, taken_cnt}, {32'd4, 32'd3});
        tick();
        check("mis_pulse_end", misalign_fault, 0);

        // Illegal funct3 010.
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0300, 4'b0100);
        tick();
        ex_valid = 1'b0;
        check("ill_pulse", illegal_branch, 1);
        check("ill_no_redirect", redirect_valid, 0);
        check("ill_cnts", {branch_cnt, taken_cnt}, {32'd5, 32'd3});
        tick();
        check("ill_pulse_end", illegal_branch, 0);

        // Reset in the middle of a stalled redirect.
        redirect_ready = 1'b0;
        drive(1'b1, 1'b0, 3'b000, 32'h0000_0300, 4'b0100);
        tick();
        ex_valid = 1'b0;
        check("rstmid_valid", redirect_valid, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_outs", {redirect_valid, flush_if_id, flush_id_ex, stall_ex,
                              misalign_fault, illegal_branch}, 0);
        check("rstmid_pc", redirect_pc, 0);
        check("rstmid_cnts", {branch_cnt, taken_cnt}, 0);
        redirect_ready = 1'b1;
        tick();
        check("rstmid_dropped", {redirect_valid, stall_ex}, 0);

        // Sixteen back-to-back taken BGEU branches, each evaluated in the first IDLE cycle.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 3'b111, 32'h0000_0400 + 32'(i * 4), 4'b0000);
            tick();
            ex_valid = 1'b0;
            check("sat_redirect", redirect_valid, 1);
            tick(); tick(); tick();
        end
        check("sat_pc", redirect_pc, 32'h43C);
        check("sat_wide_cnts", {branch_cnt, taken_cnt}, {32'd16, 32'd16});
        check("sat_narrow_cnts", {s_branch_cnt, s_taken_cnt}, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
